key_debouncer: RTL



---
 rtl/key_debouncer_pkg.sv | 21 ++
 rtl/key_debounce_channel.sv | 67 ++++++
 rtl/key_debouncer.sv | 101 ++++++++++
 3 files changed

// File: rtl/key_debouncer_pkg.sv
// key_pkg: shared register map and event-bit layout for the key debouncer.
//   ADDR_*        : register selects, decoded from byte address bits [3:2]
//   PRESS_LSB     : first bit of the press-event field in EVENTS / IRQ_EN
//   RELEASE_LSB   : first bit of the release-event field in EVENTS / IRQ_EN
//   pack_events() : places per-key press/release vectors into a 32-bit word
package key_pkg;

  localparam logic [1:0] ADDR_STATE  = 2'd0;
  localparam logic [1:0] ADDR_EVENTS = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN = 2'd2;
  localparam logic [1:0] ADDR_INFO   = 2'd3;

  localparam int PRESS_LSB   = 0;
  localparam int RELEASE_LSB = 8;

  function automatic logic [31:0] pack_events(input logic [7:0] press,
                                              input logic [7:0] rel);
    return (32'(press) << PRESS_LSB) | (32'(rel) << RELEASE_LSB);
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: one key's synchroniser, polarity normalisation and
// stability counter.
//   clk, nreset : peripheral clock, asynchronous active-low reset
//   key_raw     : raw button pin, asynchronous to clk
//   clean       : debounced level, 1 = pressed
//   rise, fall  : one-cycle pulses, combinational, high on the cycle the
//                 counter accepts a new pressed / released level
module key_debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 480_000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic nreset,
  input  logic key_raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic             IDLE_LEVEL = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             pressed_p1;
  logic [CNT_W-1:0] cnt_p2;
  logic             clean_p2;
  logic             accept;

  // Stage p0/p1: two-flop synchroniser, parked at the released pin level
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_p0 <= IDLE_LEVEL;
      sync_p1 <= IDLE_LEVEL;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed_p1 = sync_p1 ^ IDLE_LEVEL;
  assign accept     = (pressed_p1 != clean_p2) && (cnt_p2 == CNT_LAST);

  // Stage p2: stability counter; any sample matching the current clean
  // level restarts the count, so only an unbroken run is accepted
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_p2   <= '0;
      clean_p2 <= 1'b0;
    end else if (pressed_p1 != clean_p2) begin
      if (accept) begin
        clean_p2 <= pressed_p1;
        cnt_p2   <= '0;
      end else begin
        cnt_p2   <= cnt_p2 + CNT_W'(1);
      end
    end else begin
      cnt_p2 <= '0;
    end
  end

  assign clean = clean_p2;
  assign rise  = accept &  pressed_p1;
  assign fall  = accept & ~pressed_p1;

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: debounces NUM_KEYS push-buttons and exposes them over APB.
//   clk, nreset        : peripheral clock, asynchronous active-low reset
//   keys_raw           : raw button pins
//   keys_clean         : debounced keys, 1 = pressed
//   irq                : level interrupt, registered |(EVENTS & IRQ_EN)
//   apb_P*             : APB slave, zero wait states, PRDATA decoded
//                        combinationally from PADDR[3:2]
// Registers: 0x0 STATE (RO), 0x4 EVENTS (W1C), 0x8 IRQ_EN (RW), 0xC INFO (RO)
module key_debouncer
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 480_000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [NUM_KEYS-1:0] keys_clean,
  output logic                irq,
  input  logic [3:0]          apb_PADDR,
  input  logic                apb_PSEL,
  input  logic                apb_PENABLE,
  output logic                apb_PREADY,
  input  logic                apb_PWRITE,
  input  logic [31:0]         apb_PWDATA,
  output logic [31:0]         apb_PRDATA
);

  localparam logic [31:0] INFO_WORD = {16'(DEBOUNCE_CYCLES >> 4),
                                       8'(ACTIVE_LOW), 8'(NUM_KEYS)};

  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;
  logic [NUM_KEYS-1:0] press_evt;
  logic [NUM_KEYS-1:0] release_evt;
  logic [NUM_KEYS-1:0] press_en;
  logic [NUM_KEYS-1:0] release_en;
  logic [NUM_KEYS-1:0] wr_press;
  logic [NUM_KEYS-1:0] wr_release;
  logic [1:0]          reg_sel;
  logic                wr_en;
  logic                unused_apb;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clk     (clk),
      .nreset  (nreset),
      .key_raw (keys_raw[i]),
      .clean   (keys_clean[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  assign reg_sel    = apb_PADDR[3:2];
  assign wr_en      = apb_PSEL & apb_PENABLE & apb_PWRITE;
  assign wr_press   = apb_PWDATA[PRESS_LSB +: NUM_KEYS];
  assign wr_release = apb_PWDATA[RELEASE_LSB +: NUM_KEYS];
  assign apb_PREADY = 1'b1;
  assign unused_apb = ^{apb_PADDR[1:0], apb_PWDATA};

  // Event/enable registers: the hardware set is OR-ed in after the W1C mask
  // so an event arriving in the clearing cycle survives
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      press_evt   <= '0;
      release_evt <= '0;
      press_en    <= '0;
      release_en  <= '0;
      irq         <= 1'b0;
    end else begin
      if (wr_en && reg_sel == ADDR_EVENTS) begin
        press_evt   <= (press_evt   & ~wr_press)   | rise;
        release_evt <= (release_evt & ~wr_release) | fall;
      end else begin
        press_evt   <= press_evt   | rise;
        release_evt <= release_evt | fall;
      end
      if (wr_en && reg_sel == ADDR_IRQ_EN) begin
        press_en   <= wr_press;
        release_en <= wr_release;
      end
      irq <= |((press_evt & press_en) | (release_evt & release_en));
    end
  end

  always_comb begin
    apb_PRDATA = '0;
    case (reg_sel)
      ADDR_STATE:  apb_PRDATA = 32'(keys_clean);
      ADDR_EVENTS: apb_PRDATA = pack_events(8'(press_evt), 8'(release_evt));
      ADDR_IRQ_EN: apb_PRDATA = pack_events(8'(press_en), 8'(release_en));
      default:     apb_PRDATA = INFO_WORD;
    endcase
  end

endmodule
